// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encodings, divisor helper, TX FSM states.
package uart_pkg;

  localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
  localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
  localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
  localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
  localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

  // 8N1: start + 8 data + stop
  localparam int unsigned UART_FRAME_BITS = 32'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

  // Clock cycles per bit for a baud select at a given clock (MHz), truncated.
  function automatic int unsigned uart_baud_div(input logic [2:0] baud_sel,
                                                input int unsigned clk_mhz);
    int unsigned baud;
    case (baud_sel)
      BAUD_SEL_9600:  baud = 32'd9600;
      BAUD_SEL_19200: baud = 32'd19200;
      BAUD_SEL_38400: baud = 32'd38400;
      BAUD_SEL_57600: baud = 32'd57600;
      default:        baud = 32'd115200;
    endcase
    return (clk_mhz * 32'd1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  // Full when wrap bits differ and index bits match
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Next pointer values; overflow/underflow requests are ignored
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int UART_CLK_MHZ = 50,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    baud_sel_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          rs232_tx_data_o,
  output logic                          tx_busy_o,
  output logic                          rs232_tx_int
);

  localparam int unsigned DIV_9600   = uart_baud_div(BAUD_SEL_9600,   UART_CLK_MHZ);
  localparam int unsigned DIV_19200  = uart_baud_div(BAUD_SEL_19200,  UART_CLK_MHZ);
  localparam int unsigned DIV_38400  = uart_baud_div(BAUD_SEL_38400,  UART_CLK_MHZ);
  localparam int unsigned DIV_57600  = uart_baud_div(BAUD_SEL_57600,  UART_CLK_MHZ);
  localparam int unsigned DIV_115200 = uart_baud_div(BAUD_SEL_115200, UART_CLK_MHZ);
  // Counter must hold the slowest divisor minus one
  localparam int CNT_W = $clog2(DIV_9600);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;       // latched divisor minus one
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             line_q, line_d;
  logic             busy_q, busy_d;
  logic             int_q, int_d;

  logic [CNT_W-1:0] div_sel_s;
  logic             push_s, pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]       fifo_data_s;
  logic [LW-1:0]    fifo_level_s;

  assign tx_ready_o      = (fifo_level_s != LW'(FIFO_DEPTH));
  assign push_s          = tx_valid_i & tx_ready_o;
  assign fifo_level_o    = fifo_level_s;
  assign rs232_tx_data_o = line_q;
  assign tx_busy_o       = busy_q;
  assign rs232_tx_int    = int_q;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (tx_data_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Map live baud select onto its elaboration-time divisor (minus one)
  always_comb begin
    div_sel_s = CNT_W'(DIV_115200 - 32'd1);
    case (baud_sel_i)
      BAUD_SEL_9600:  div_sel_s = CNT_W'(DIV_9600   - 32'd1);
      BAUD_SEL_19200: div_sel_s = CNT_W'(DIV_19200  - 32'd1);
      BAUD_SEL_38400: div_sel_s = CNT_W'(DIV_38400  - 32'd1);
      BAUD_SEL_57600: div_sel_s = CNT_W'(DIV_57600  - 32'd1);
      default:        div_sel_s = CNT_W'(DIV_115200 - 32'd1);
    endcase
  end

  // Frame sequencing: next state, counters, line level and stop pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    int_d   = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_data_s;
          div_d   = div_sel_s;
          state_d = ST_START;
          line_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          line_d  = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          line_d  = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            line_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            line_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_data_s;
            div_d   = div_sel_s;
            state_d = ST_START;
            line_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            line_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // pulse lands on the final stop-bit cycle
          int_d = ((cnt_q + CNT_W'(1)) == div_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Transmitter state and registered outputs; reset forces the line idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      int_q   <= int_d;
    end
  end

endmodule
